serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
// The master drives the request and operands, and the slave returns the status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through one full-subtractor cell with a registered borrow.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic             cell_diff_s;
    logic             cell_borrow_s;
    logic [WIDTH-1:0] part_d;
    logic             last_s;
    logic             accept_s;
    logic             finish_s;

    // One-bit full subtractor: returns {borrow_out, diff}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    // Cell evaluation and the next partial result, with the new diff bit entering at the MSB.
    always_comb begin
        {cell_borrow_s, cell_diff_s} = full_sub(a_q[0], b_q[0], brw_q);
        part_d   = {cell_diff_s, part_q[WIDTH-1:1]};
        last_s   = (cnt_q == CW'(WIDTH - 1));
        accept_s = 1'b0;
        finish_s = 1'b0;
        if (state_q == IDLE) begin
            accept_s = bus.start;
        end else if (state_q == SHIFT) begin
            finish_s = last_s;
        end else begin
            accept_s = 1'b0;
            finish_s = 1'b0;
        end
    end

    // Control FSM, datapath shift registers and the registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        brw_q   <= bus.bin;
                        cnt_q   <= '0;
                        part_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    brw_q  <= cell_borrow_s;
                    part_q <= part_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_s) begin
                        diff_q   <= part_d;
                        borrow_q <= cell_borrow_s;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_sign_q;
    logic b_sign_q;
    logic ovf_q;

    // Operand signs are kept from acceptance because the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept_s) begin
            a_sign_q <= bus.a[WIDTH-1];
            b_sign_q <= bus.b[WIDTH-1];
        end else if (finish_s) begin
            ovf_q <= (a_sign_q != b_sign_q) && (cell_diff_s != a_sign_q);
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at request time and
// compared when done pulses; handshake timing, ignored restarts and mid-operation reset are probed.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        logic [W:0] wide;
        wide     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.diff   = wide[W-1:0];
        e.borrow = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
`else
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    // Result monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("diff",   {24'd0, bus.diff}, {24'd0, e.diff});
                check_val("borrow", {31'd0, bus.borrow}, {31'd0, e.borrow});
                check_val("ovf",    {31'd0, bus.ovf}, {31'd0, e.ovf});
            end
        end
    end

    task automatic check_outputs_clear(input string tag);
        check_val({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
        check_val({tag, "_done"},   {31'd0, bus.done}, 32'd0);
        check_val({tag, "_diff"},   {24'd0, bus.diff}, 32'd0);
        check_val({tag, "_borrow"}, {31'd0, bus.borrow}, 32'd0);
        check_val({tag, "_ovf"},    {31'd0, bus.ovf}, 32'd0);
    endtask

    // One operation; poke=1 re-pulses start with other operands on cycle 3.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit poke);
        int k;
        int busy_cnt;
        int d0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        sb.push_back(model(a, b, bin));
        d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a; bus.b = a ^ b; bus.bin = ~bin;
        busy_cnt = bus.busy ? 1 : 0;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
            if (poke && k == 3) begin
                bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'hC4; bus.bin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
        end
        check_val("done_latency", k, W);
        check_val("busy_cycles", busy_cnt, W);
        @(negedge clk);
        check_val("done_pulse_width", {31'd0, bus.done}, 32'd0);
        if (poke) begin
            repeat (2 * W) @(negedge clk);
            check_val("single_done", done_cnt - d0, 1);
        end
    endtask

    initial begin
        int d0;
        int k;
        int gap;
        checks = 0; errors = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_clear("reset");
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(8'h10, 8'h20, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, 1'b1);

        // Reset while idle with a non-zero result held.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_clear("idle_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Reset on cycle 4 of an operation discards it.
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_clear("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        check_val("no_done_after_reset", done_cnt - d0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);

        // start held high: back-to-back acceptance every W+2 cycles.
        @(negedge clk);
        bus.a = 8'hC3; bus.b = 8'h5E; bus.bin = 1'b1; bus.start = 1'b1;
        sb.push_back(model(8'hC3, 8'h5E, 1'b1));
        sb.push_back(model(8'hC3, 8'h5E, 1'b1));
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        gap = 0;
        @(negedge clk);
        gap = 1;
        while (!bus.done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        bus.start = 1'b0;
        check_val("b2b_interval", gap, W + 2);
        repeat (2 * W) @(negedge clk);
        check_val("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
